mfp_adc_max10_sequencer: RTL and testbench
==========================================

// Module: mfp_adc_max10_sequencer
// PURPOSE
//  Scans a mask of MAX10 ADC channels through the ADC core's Avalon-ST command/response ports.
//  Holds the latest 12-bit result for each channel so software can read it over a simple read port.
//  Sits in mfp_system between the AHB-Lite ADC register slave and the adc IP instance.
//  The adc IP and this block share HCLK.
// PARAMETERS
//  N_CHANNELS     8     scan slots; slot i drives ADC channel i+FIRST_CHANNEL
//  FIRST_CHANNEL  1     ADC channel number of slot 0; slot N_CHANNELS-1 must map to an ADC channel <=17
//  TIMEOUT        1023  max cycles from command accept to response; 10-bit counter
// PORTS
//  HCLK           in   1           system clock; also the adc clock_clk
//  HRESETn        in   1           synchronous reset, active low
//  start          in   1           pulse: begin one scan pass (ignored while busy)
//  continuous     in   1           1: restart the pass automatically at end of pass
//  ch_mask        in   N_CHANNELS  enabled slots; latched at the start of each pass
//  busy           out  1           a pass is in progress
//  done           out  1           1-cycle pulse at the end of each pass
//  error          out  1           sticky: timeout or channel mismatch; cleared by start
//  rd_idx         in   $clog2(N)   result read index
//  rd_data        out  12          result[rd_idx]; combinational read
//  ADC_C_Valid    out  1           command valid
//  ADC_C_Channel  out  5           command channel
//  ADC_C_SOP      out  1           command start-of-packet; = ADC_C_Valid
//  ADC_C_EOP      out  1           command end-of-packet; = ADC_C_Valid
//  ADC_C_Ready    in   1           command accepted
//  ADC_R_Valid    in   1           response valid
//  ADC_R_Channel  in   5           response channel
//  ADC_R_Data     in   12          response sample
// BEHAVIOUR
//  Reset values: busy=0, done=0, error=0, ADC_C_Valid=0, ADC_C_Channel=0, all results=0, FSM=IDLE.
//  FSM states: IDLE, PICK, CMD, WAIT, STORE.
//  - IDLE -> PICK: start=1 and ch_mask!=0.
//    - Latches ch_mask into mask_q, clears error, sets busy=1.
//    - start with ch_mask==0 is ignored.
//  - PICK: selects the lowest set bit of mask_q at index >= slot (slot=0 at pass start).
//    - Found: go to CMD.
//    - None left: done=1 for 1 cycle. Then go to PICK with slot=0 and a fresh mask latch if continuous=1.
//      Otherwise go to IDLE with busy=0.
//  - CMD: ADC_C_Valid=1 and ADC_C_Channel=slot+FIRST_CHANNEL, held stable until ADC_C_Ready=1.
//    - Go to WAIT on the Valid&Ready cycle; Valid drops the next cycle.
//    - Only one command is outstanding at any time.
//  - WAIT: timeout counter counts from 0.
//    - ADC_R_Valid with matching ADC_R_Channel: go to STORE.
//    - ADC_R_Valid with wrong channel: error=1, sample dropped, slot advances.
//    - Counter reaches TIMEOUT: error=1, result unchanged, slot advances.
//  - STORE: result[slot] <= sample; slot+1; back to PICK.
//    - The new value is visible on rd_data in the cycle after STORE.
//  Timing: minimum 4 cycles per channel (PICK, CMD, WAIT, STORE) when Ready and response are immediate.
//  ADC_R_Valid outside WAIT is ignored and does not set error.
//  continuous falling mid-pass: the current pass finishes, then the block goes to IDLE.
//  start while busy: ignored; error is not cleared.
//  Reset mid-operation: immediate return to IDLE; an outstanding command is abandoned.
//  Results persist across passes; slots not in the mask keep their old value.
// CONFIGURATION
//  MFP_ADC_SEQ_AVERAGE_EN defined:
//  - Each slot takes 4 samples per pass, i.e. 4 CMD/WAIT rounds into a 14-bit accumulator.
//  - The stored result is acc[13:2] (truncating).
//  - A timeout or mismatch on any of the 4 samples aborts that slot: result unchanged, error=1.
//  MFP_ADC_SEQ_AVERAGE_EN undefined: single sample per slot, no accumulator logic.
// STRUCTURE
//  mfp_adc_max10_sequencer.vh holds:
//  - state encodings
//  - the FIRST_CHANNEL/slot-to-channel mapping macro
//  - default TIMEOUT
//  - AVG_SHIFT=2
//  One sub-module, mfp_adc_seq_next_slot (combinational): inputs mask_q and slot; outputs found and next_slot.
//  It finds the lowest set bit at index >= slot.
// TESTING
//  Bench uses an ADC core model with programmable Ready and response delay.
//  1. mask=8'b0000_0101, start, Ready and response after 2 cycles.
//     -> commands on ch 1 then ch 3; result[0], result[2] written; done pulse; busy=0; error=0.
//  2. Model holds Ready=0 for 5 cycles.
//     -> ADC_C_Valid and ADC_C_Channel stable all 5 cycles; exactly 1 command accepted.
//  3. Model never responds on ch 2 (TIMEOUT=15).
//     -> error=1 after 15 WAIT cycles; result[1] unchanged; scan continues to the next slot.
//  4. Response carries channel 7 for a ch 1 command.
//     -> error=1; result[0] unchanged; a new start clears error.
//  5. continuous=1, mask=8'h81.
//     -> repeating commands ch1, ch8, ch1...; done once per pass.
//     -> HRESETn=0 mid-WAIT gives IDLE next cycle and all outputs at reset values.
//  6. MFP_ADC_SEQ_AVERAGE_EN defined, samples 100, 101, 102, 103 -> result=101.
//     -> mask=0 plus start -> busy stays 0.

Source files
------------

// File: rtl/mfp_adc_max10_sequencer_pkg.sv
// Shared types and constants for the MAX10 ADC scan sequencer.
package mfp_adc_max10_sequencer_pkg;

  // state   | meaning
  // IDLE    | no pass running, waiting for start
  // PICK    | find next enabled slot, or end the pass
  // CMD     | command valid, holding until ADC accepts it
  // WAIT    | command accepted, waiting for the response
  // STORE   | write the sample/average into the result slot
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_CMD,
    ST_WAIT,
    ST_STORE
  } seq_state_e;

  localparam int TIMEOUT_DEFAULT = 1023;
  localparam int TMO_W           = 10;
  localparam int AVG_SHIFT       = 2;
  localparam int AVG_SAMPLES     = 1 << AVG_SHIFT;
  localparam int ACC_W           = 12 + AVG_SHIFT;

  // Slot i drives ADC channel i + first_ch.
  function automatic logic [4:0] slot_to_ch(input int unsigned slot, input int unsigned first_ch);
    return 5'(slot + first_ch);
  endfunction

endpackage

// File: rtl/mfp_adc_max10_sequencer_if.sv
// Avalon-ST command/response link between the sequencer and the MAX10 ADC core.
interface mfp_adc_max10_sequencer_if;
  logic        ADC_C_Valid;
  logic [4:0]  ADC_C_Channel;
  logic        ADC_C_SOP;
  logic        ADC_C_EOP;
  logic        ADC_C_Ready;
  logic        ADC_R_Valid;
  logic [4:0]  ADC_R_Channel;
  logic [11:0] ADC_R_Data;

  modport master (
    output ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    input  ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );

  modport slave (
    input  ADC_C_Valid, ADC_C_Channel, ADC_C_SOP, ADC_C_EOP,
    output ADC_C_Ready, ADC_R_Valid, ADC_R_Channel, ADC_R_Data
  );
endinterface

// File: rtl/mfp_adc_max10_sequencer_next_slot.sv
// Finds the lowest set mask bit at an index >= slot_i.
module mfp_adc_seq_next_slot #(
  parameter int N_CHANNELS = 8,
  parameter int SLOT_W     = $clog2(N_CHANNELS) + 1
) (
  input  logic [N_CHANNELS-1:0] mask_i,
  input  logic [SLOT_W-1:0]     slot_i,
  output logic                  found_o,
  output logic [SLOT_W-1:0]     next_slot_o
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    found_o     = 1'b0;
    next_slot_o = '0;
    for (int i = N_CHANNELS - 1; i >= 0; i--) begin
      if (mask_i[i] && (SLOT_W'(i) >= slot_i)) begin
        found_o     = 1'b1;
        next_slot_o = SLOT_W'(i);
      end
    end
  end

endmodule

// File: rtl/mfp_adc_max10_sequencer.sv
// MAX10 ADC scan sequencer: walks the enabled slots, issues one command at a
// time to the ADC core and keeps the latest 12-bit result per slot.
// Optional build macro MFP_ADC_SEQ_AVERAGE_EN: four samples per slot, stored
// as the truncated mean.
module mfp_adc_max10_sequencer
  import mfp_adc_max10_sequencer_pkg::*;
#(
  parameter int N_CHANNELS    = 8,
  parameter int FIRST_CHANNEL = 1,
  parameter int TIMEOUT       = TIMEOUT_DEFAULT
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          start,
  input  logic                          continuous,
  input  logic [N_CHANNELS-1:0]         ch_mask,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  input  logic [$clog2(N_CHANNELS)-1:0] rd_idx,
  output logic [11:0]                   rd_data,
  mfp_adc_max10_sequencer_if.master     adc
);

  localparam int SLOT_W = $clog2(N_CHANNELS) + 1;

  seq_state_e             state_q, state_d;
  logic [N_CHANNELS-1:0]  mask_q, mask_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   error_q, error_d;
  logic [11:0]            res_q [N_CHANNELS];
  logic                   wr_en;
  logic [11:0]            store_val;
  logic                   found;
  logic [SLOT_W-1:0]      next_slot;
  logic [4:0]             cur_ch;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
  logic [ACC_W-1:0]       acc_q, acc_d;
  logic [AVG_SHIFT-1:0]   cnt_q, cnt_d;
`else
  logic [11:0]            sample_q, sample_d;
`endif

  mfp_adc_seq_next_slot #(
    .N_CHANNELS (N_CHANNELS),
    .SLOT_W     (SLOT_W)
  ) u_next_slot (
    .mask_i      (mask_q),
    .slot_i      (slot_q),
    .found_o     (found),
    .next_slot_o (next_slot)
  );

  assign cur_ch = slot_to_ch(32'(slot_q), FIRST_CHANNEL);
  assign busy   = (state_q != ST_IDLE);
  assign error  = error_q;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
  assign store_val = 12'(acc_q >> AVG_SHIFT);
`else
  assign store_val = sample_q;
`endif
  assign rd_data = (32'(rd_idx) < N_CHANNELS) ? res_q[rd_idx] : '0;
  assign adc.ADC_C_SOP = adc.ADC_C_Valid;
  assign adc.ADC_C_EOP = adc.ADC_C_Valid;

  // Next-state, command outputs and bookkeeping for the scan FSM.
  always_comb begin
    state_d           = state_q;
    mask_d            = mask_q;
    slot_d            = slot_q;
    tmo_d             = tmo_q;
    error_d           = error_q;
    done              = 1'b0;
    wr_en             = 1'b0;
    adc.ADC_C_Valid   = 1'b0;
    adc.ADC_C_Channel = '0;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
    acc_d = acc_q;
    cnt_d = cnt_q;
`else
    sample_d = sample_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start && (ch_mask != '0)) begin
          mask_d  = ch_mask;
          slot_d  = '0;
          error_d = 1'b0;
          state_d = ST_PICK;
        end
      end
      ST_PICK: begin
        if (found) begin
          slot_d  = next_slot;
          state_d = ST_CMD;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
          acc_d = '0;
          cnt_d = '0;
`endif
        end else begin
          done = 1'b1;
          // A zero mask at restart would spin on done pulses, so stop instead.
          if (continuous && (ch_mask != '0)) begin
            mask_d  = ch_mask;
            slot_d  = '0;
            state_d = ST_PICK;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_CMD: begin
        adc.ADC_C_Valid   = 1'b1;
        adc.ADC_C_Channel = cur_ch;
        if (adc.ADC_C_Ready) begin
          tmo_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (adc.ADC_R_Valid) begin
          if (adc.ADC_R_Channel == cur_ch) begin
`ifdef MFP_ADC_SEQ_AVERAGE_EN
            acc_d = acc_q + ACC_W'(adc.ADC_R_Data);
            if (cnt_q == AVG_SHIFT'(AVG_SAMPLES - 1)) begin
              state_d = ST_STORE;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = ST_CMD;
            end
`else
            sample_d = adc.ADC_R_Data;
            state_d  = ST_STORE;
`endif
          end else begin
            error_d = 1'b1;
            slot_d  = slot_q + 1'b1;
            state_d = ST_PICK;
          end
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          slot_d  = slot_q + 1'b1;
          state_d = ST_PICK;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      ST_STORE: begin
        wr_en   = 1'b1;
        slot_d  = slot_q + 1'b1;
        state_d = ST_PICK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      slot_q  <= '0;
      tmo_q   <= '0;
      error_q <= 1'b0;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
      acc_q <= '0;
      cnt_q <= '0;
`else
      sample_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      slot_q  <= slot_d;
      tmo_q   <= tmo_d;
      error_q <= error_d;
`ifdef MFP_ADC_SEQ_AVERAGE_EN
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`else
      sample_q <= sample_d;
`endif
    end
  end

  // Result storage; slots outside the mask keep their previous value.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      for (int i = 0; i < N_CHANNELS; i++) res_q[i] <= '0;
    end else if (wr_en) begin
      res_q[slot_q[SLOT_W-2:0]] <= store_val;
    end
  end

endmodule

// File: tb/tb_mfp_adc_max10_sequencer.sv
// Directed bench for the MAX10 ADC scan sequencer with a simple ADC core model.
module tb_mfp_adc_max10_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic        start = 1'b0;
  logic        continuous = 1'b0;
  logic [7:0]  ch_mask = 8'h00;
  logic        busy, done, error;
  logic [2:0]  rd_idx = 3'd0;
  logic [11:0] rd_data;

  mfp_adc_max10_sequencer_if adc_if ();

  mfp_adc_max10_sequencer #(
    .N_CHANNELS    (8),
    .FIRST_CHANNEL (1),
    .TIMEOUT       (15)
  ) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .start      (start),
    .continuous (continuous),
    .ch_mask    (ch_mask),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rd_idx     (rd_idx),
    .rd_data    (rd_data),
    .adc        (adc_if)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  // ADC model controls
  int          m_rdy_dly = 0;
  int          m_resp_dly = 0;
  bit          m_noresp_en = 0;
  logic [4:0]  m_noresp_ch = 5'd0;
  bit          m_bad_en = 0;
  logic [4:0]  m_bad_ch = 5'd0;
  logic [11:0] m_data [$];

  // Observation state (written only by the posedge monitor)
  int         cyc = 0;
  int         n_acc = 0;
  int         done_cnt = 0;
  int         viol = 0;
  int         vw_cnt = 0;
  int         acc_ch [0:127];
  int         acc_cyc [0:127];
  bit         snap_accept = 0;
  logic [4:0] snap_ch = 5'd0;
  bit         prev_valid = 0;
  bit         prev_accept = 0;
  logic [4:0] prev_ch = 5'd0;

  // Monitor: command acceptance log, done pulses, command stability.
  always @(posedge HCLK) begin
    cyc++;
    if (done === 1'b1) done_cnt++;
    if (adc_if.ADC_C_Valid === 1'b1 && adc_if.ADC_C_Ready !== 1'b1) vw_cnt++;
    if (HRESETn && prev_valid && !prev_accept &&
        (adc_if.ADC_C_Valid !== 1'b1 || adc_if.ADC_C_Channel !== prev_ch)) viol++;
    snap_accept = (adc_if.ADC_C_Valid === 1'b1) && (adc_if.ADC_C_Ready === 1'b1);
    snap_ch     = adc_if.ADC_C_Channel;
    if (snap_accept && n_acc < 128) begin
      acc_ch[n_acc]  = int'(adc_if.ADC_C_Channel);
      acc_cyc[n_acc] = cyc;
      n_acc++;
    end
    prev_valid  = (adc_if.ADC_C_Valid === 1'b1);
    prev_accept = snap_accept;
    prev_ch     = adc_if.ADC_C_Channel;
  end

  // ADC core model: programmable Ready delay and response delay.
  int         rdy_cnt = 0;
  int         pend_cnt = 0;
  bit         pend = 0;
  logic [4:0] pend_ch = 5'd0;
  logic [11:0] pend_data = 12'd0;

  always @(negedge HCLK) begin
    adc_if.ADC_R_Valid = 1'b0;
    if (!HRESETn) begin
      pend                 = 0;
      rdy_cnt              = 0;
      adc_if.ADC_C_Ready   = 1'b0;
      adc_if.ADC_R_Channel = 5'd0;
      adc_if.ADC_R_Data    = 12'd0;
    end else begin
      if (snap_accept && !(m_noresp_en && snap_ch == m_noresp_ch)) begin
        pend     = 1;
        pend_cnt = 0;
        pend_ch  = m_bad_en ? m_bad_ch : snap_ch;
        if (m_data.size() > 0) pend_data = m_data.pop_front();
        else pend_data = 12'd0;
      end
      if (pend) begin
        if (pend_cnt >= m_resp_dly) begin
          adc_if.ADC_R_Valid   = 1'b1;
          adc_if.ADC_R_Channel = pend_ch;
          adc_if.ADC_R_Data    = pend_data;
          pend = 0;
        end else begin
          pend_cnt++;
        end
      end
      if (adc_if.ADC_C_Valid === 1'b1) begin
        adc_if.ADC_C_Ready = (rdy_cnt >= m_rdy_dly);
        rdy_cnt++;
      end else begin
        adc_if.ADC_C_Ready = 1'b0;
        rdy_cnt = 0;
      end
    end
  end

  task automatic pulse_start(input logic [7:0] mask);
    @(negedge HCLK);
    ch_mask = mask;
    start   = 1'b1;
    @(negedge HCLK);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (busy === 1'b0) begin ok = 1; break; end
    end
  endtask

  task automatic wait_acc(input int target, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge HCLK);
      if (n_acc >= target) begin ok = 1; break; end
    end
  endtask

  task automatic read_res(input int idx, output logic [11:0] val);
    @(negedge HCLK);
    rd_idx = 3'(idx);
    #1 val = rd_data;
  endtask

  task automatic test_reset();
    logic [11:0] v;
    HRESETn = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    n_checks++;
    if ({busy, done, error} !== 3'b000) $display("FAIL reset_flags busy/done/error=%b want 000", {busy, done, error});
    else n_pass++;
    n_checks++;
    if (adc_if.ADC_C_Valid !== 1'b0 || adc_if.ADC_C_Channel !== 5'd0)
      $display("FAIL reset_cmd valid=%b ch=%0d want 0/0", adc_if.ADC_C_Valid, adc_if.ADC_C_Channel);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      read_res(i, v);
      n_checks++;
      if (v !== 12'd0) $display("FAIL reset_result[%0d] got %h want 000", i, v);
      else n_pass++;
    end
  endtask

  task automatic test_basic_scan();
    int b, d0;
    bit ok;
    logic [11:0] v;
    m_data.delete();
    m_data.push_back(12'h123);
    m_data.push_back(12'h456);
    m_rdy_dly = 2; m_resp_dly = 2;
    b = n_acc; d0 = done_cnt;
    pulse_start(8'b0000_0101);
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL basic_idle timeout busy=%b want 0", busy); else n_pass++;
    n_checks++;
    if (n_acc - b != 2 || acc_ch[b] != 1 || acc_ch[b+1] != 3)
      $display("FAIL basic_cmds count=%0d ch=%0d,%0d want 2 cmds ch 1,3", n_acc - b, acc_ch[b], acc_ch[b+1]);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 1) $display("FAIL basic_done pulses=%0d want 1", done_cnt - d0); else n_pass++;
    n_checks++;
    if (error !== 1'b0) $display("FAIL basic_error got %b want 0", error); else n_pass++;
    read_res(0, v);
    n_checks++;
    if (v !== 12'h123) $display("FAIL basic_res0 got %h want 123", v); else n_pass++;
    read_res(2, v);
    n_checks++;
    if (v !== 12'h456) $display("FAIL basic_res2 got %h want 456", v); else n_pass++;
    read_res(1, v);
    n_checks++;
    if (v !== 12'h000) $display("FAIL basic_res1 got %h want 000", v); else n_pass++;
  endtask

  task automatic test_ready_stall();
    int b, w0, v0;
    bit ok;
    logic [11:0] v;
    m_data.delete();
    m_data.push_back(12'h0AA);
    m_rdy_dly = 5; m_resp_dly = 0;
    b = n_acc; w0 = vw_cnt; v0 = viol;
    pulse_start(8'h10);
    wait_idle(300, ok);
    n_checks++;
    if (!ok) $display("FAIL stall_idle timeout busy=%b want 0", busy); else n_pass++;
    n_checks++;
    if (n_acc - b != 1 || acc_ch[b] != 5)
      $display("FAIL stall_cmds count=%0d ch=%0d want 1 cmd ch 5", n_acc - b, acc_ch[b]);
    else n_pass++;
    n_checks++;
    if (vw_cnt - w0 != 5) $display("FAIL stall_wait_cycles got %0d want 5", vw_cnt - w0); else n_pass++;
    n_checks++;
    if (viol != v0) $display("FAIL stall_stability changes=%0d want 0", viol - v0); else n_pass++;
    read_res(4, v);
    n_checks++;
    if (v !== 12'h0AA) $display("FAIL stall_res4 got %h want 0aa", v); else n_pass++;
  endtask

  task automatic test_timeout();
    int b;
    bit ok;
    logic [11:0] v;
    m_rdy_dly = 0; m_resp_dly = 0;
    m_data.delete();
    m_data.push_back(12'h222);
    pulse_start(8'h02);
    wait_idle(300, ok);
    n_checks++;
    if (!ok || error !== 1'b0) $display("FAIL tmo_prefill ok=%0d error=%b want 1/0", ok, error); else n_pass++;
    m_data.delete();
    m_data.push_back(12'h333);
    m_noresp_en = 1; m_noresp_ch = 5'd2;
    b = n_acc;
    pulse_start(8'h06);
    wait_idle(300, ok);
    m_noresp_en = 0;
    n_checks++;
    if (!ok) $display("FAIL tmo_idle timeout busy=%b want 0", busy); else n_pass++;
    n_checks++;
    if (error !== 1'b1) $display("FAIL tmo_error got %b want 1", error); else n_pass++;
    n_checks++;
    if (n_acc - b != 2 || acc_ch[b] != 2 || acc_ch[b+1] != 3)
      $display("FAIL tmo_cmds count=%0d ch=%0d,%0d want 2 cmds ch 2,3", n_acc - b, acc_ch[b], acc_ch[b+1]);
    else n_pass++;
    // 15 WAIT cycles, one PICK, one CMD before the next accept
    n_checks++;
    if (acc_cyc[b+1] - acc_cyc[b] != 17)
      $display("FAIL tmo_gap got %0d cycles want 17", acc_cyc[b+1] - acc_cyc[b]);
    else n_pass++;
    read_res(1, v);
    n_checks++;
    if (v !== 12'h222) $display("FAIL tmo_res1 got %h want 222", v); else n_pass++;
    read_res(2, v);
    n_checks++;
    if (v !== 12'h333) $display("FAIL tmo_res2 got %h want 333", v); else n_pass++;
  endtask

  task automatic test_mismatch();
    int b;
    bit ok;
    logic [11:0] v;
    m_rdy_dly = 0; m_resp_dly = 1;
    m_data.delete();
    m_data.push_back(12'hFFF);
    m_bad_en = 1; m_bad_ch = 5'd7;
    pulse_start(8'h01);
    wait_idle(300, ok);
    m_bad_en = 0;
    n_checks++;
    if (!ok || error !== 1'b1) $display("FAIL mis_error ok=%0d error=%b want 1/1", ok, error); else n_pass++;
    read_res(0, v);
    n_checks++;
    if (v !== 12'h123) $display("FAIL mis_res0 got %h want 123", v); else n_pass++;
    m_data.delete();
    m_data.push_back(12'h0C4);
    m_rdy_dly = 3;
    b = n_acc;
    pulse_start(8'h01);
    n_checks++;
    if (error !== 1'b0 || busy !== 1'b1) $display("FAIL mis_clear error=%b busy=%b want 0/1", error, busy); else n_pass++;
    pulse_start(8'hFF);
    wait_idle(300, ok);
    n_checks++;
    if (!ok || n_acc - b != 1) $display("FAIL busy_start_ignored ok=%0d cmds=%0d want 1/1", ok, n_acc - b); else n_pass++;
    read_res(0, v);
    n_checks++;
    if (v !== 12'h0C4) $display("FAIL mis_res0_new got %h want 0c4", v); else n_pass++;
  endtask

  task automatic test_continuous();
    int b, d0;
    bit ok;
    logic [11:0] v;
    m_rdy_dly = 0; m_resp_dly = 0;
    m_data.delete();
    for (int i = 0; i < 8; i++) m_data.push_back(12'(12'h700 + i));
    b = n_acc; d0 = done_cnt;
    @(negedge HCLK);
    continuous = 1'b1;
    pulse_start(8'h81);
    wait_acc(b + 5, 300, ok);
    continuous = 1'b0;
    n_checks++;
    if (!ok) $display("FAIL cont_progress cmds=%0d want 5", n_acc - b); else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 2) $display("FAIL cont_done_per_pass got %0d want 2", done_cnt - d0); else n_pass++;
    wait_idle(300, ok);
    n_checks++;
    if (!ok || n_acc - b != 6) $display("FAIL cont_stop ok=%0d cmds=%0d want 1/6", ok, n_acc - b); else n_pass++;
    n_checks++;
    if (acc_ch[b] != 1 || acc_ch[b+1] != 8 || acc_ch[b+2] != 1 || acc_ch[b+3] != 8 ||
        acc_ch[b+4] != 1 || acc_ch[b+5] != 8)
      $display("FAIL cont_order ch=%0d,%0d,%0d,%0d,%0d,%0d want 1,8,1,8,1,8",
               acc_ch[b], acc_ch[b+1], acc_ch[b+2], acc_ch[b+3], acc_ch[b+4], acc_ch[b+5]);
    else n_pass++;
    n_checks++;
    if (done_cnt - d0 != 3) $display("FAIL cont_done_total got %0d want 3", done_cnt - d0); else n_pass++;
    read_res(7, v);
    n_checks++;
    if (v !== 12'h705) $display("FAIL cont_res7 got %h want 705", v); else n_pass++;

    // Reset while a response is outstanding
    m_resp_dly = 10;
    b = n_acc;
    @(negedge HCLK);
    continuous = 1'b1;
    pulse_start(8'h81);
    wait_acc(b + 1, 100, ok);
    HRESETn = 1'b0;
    @(posedge HCLK);
    #1;
    n_checks++;
    if (!ok || {busy, done, error} !== 3'b000)
      $display("FAIL rst_mid_flags ok=%0d busy/done/error=%b want 1/000", ok, {busy, done, error});
    else n_pass++;
    n_checks++;
    if (adc_if.ADC_C_Valid !== 1'b0 || adc_if.ADC_C_Channel !== 5'd0)
      $display("FAIL rst_mid_cmd valid=%b ch=%0d want 0/0", adc_if.ADC_C_Valid, adc_if.ADC_C_Channel);
    else n_pass++;
    rd_idx = 3'd7;
    #1;
    n_checks++;
    if (rd_data !== 12'd0) $display("FAIL rst_mid_res7 got %h want 000", rd_data); else n_pass++;
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (20) @(negedge HCLK);
    n_checks++;
    if (busy !== 1'b0 || n_acc - b != 1) $display("FAIL rst_stays_idle busy=%b cmds=%0d want 0/1", busy, n_acc - b); else n_pass++;
    continuous = 1'b0;
    m_resp_dly = 0;
  endtask

  task automatic test_mask_zero();
    int hi;
    hi = 0;
    pulse_start(8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge HCLK);
      if (busy !== 1'b0) hi++;
    end
    n_checks++;
    if (hi != 0) $display("FAIL mask_zero busy_cycles=%0d want 0", hi); else n_pass++;
  endtask

`ifdef MFP_ADC_SEQ_AVERAGE_EN
  task automatic test_average();
    int b;
    bit ok;
    logic [11:0] v;
    m_rdy_dly = 0; m_resp_dly = 0;
    m_data.delete();
    m_data.push_back(12'd100);
    m_data.push_back(12'd101);
    m_data.push_back(12'd102);
    m_data.push_back(12'd103);
    b = n_acc;
    pulse_start(8'h01);
    wait_idle(300, ok);
    n_checks++;
    if (!ok || n_acc - b != 4) $display("FAIL avg_cmds ok=%0d cmds=%0d want 1/4", ok, n_acc - b); else n_pass++;
    read_res(0, v);
    n_checks++;
    if (v !== 12'd101) $display("FAIL avg_res0 got %0d want 101", v); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_ready_stall();
    test_timeout();
    test_mismatch();
    test_continuous();
    test_mask_zero();
`ifdef MFP_ADC_SEQ_AVERAGE_EN
    test_average();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
